// File: rtl/cpl_req_pkg.sv
// Shared types for the completion enqueue requester.
// Holds the FSM state encoding and the completion record width.
package cpl_req_pkg;

   localparam int CPL_DATA_WIDTH = 128;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_RESP,
      S_WRITE,
      S_WAIT_DONE,
      S_COMMIT
   } state_t;

endpackage

// File: rtl/cpl_enqueue_requester.sv
// Completion enqueue requester: takes one completion event, asks the queue
// manager for a slot, writes the record there, then commits the operation.
// Ports: s_cpl_* event in; m_enq_req_* slot request; s_enq_resp_* slot
// response; m_wr_* record write; s_wr_done write landed; m_commit_* commit
// pulse; event_drop pulse per discarded event/response.
// Option CPL_REQ_DROP_CNT_EN adds drop_count, a saturating 32-bit drop tally.
module cpl_enqueue_requester
   import cpl_req_pkg::*;
#(
   parameter int QUEUE_INDEX_WIDTH = 7,
   parameter int REQ_TAG_WIDTH     = 4,
   parameter int OP_TAG_WIDTH      = 8,
   parameter int ADDR_WIDTH        = 64
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [QUEUE_INDEX_WIDTH-1:0] s_cpl_queue,
   input  logic [CPL_DATA_WIDTH-1:0]    s_cpl_data,
   input  logic                         s_cpl_valid,
   output logic                         s_cpl_ready,
   output logic [QUEUE_INDEX_WIDTH-1:0] m_enq_req_queue,
   output logic [REQ_TAG_WIDTH-1:0]     m_enq_req_tag,
   output logic                         m_enq_req_valid,
   input  logic                         m_enq_req_ready,
   input  logic [ADDR_WIDTH-1:0]        s_enq_resp_addr,
   input  logic                         s_enq_resp_phase,
   input  logic [REQ_TAG_WIDTH-1:0]     s_enq_resp_tag,
   input  logic [OP_TAG_WIDTH-1:0]      s_enq_resp_op_tag,
   input  logic                         s_enq_resp_full,
   input  logic                         s_enq_resp_error,
   input  logic                         s_enq_resp_valid,
   output logic                         s_enq_resp_ready,
   output logic [ADDR_WIDTH-1:0]        m_wr_addr,
   output logic [CPL_DATA_WIDTH-1:0]    m_wr_data,
   output logic                         m_wr_valid,
   input  logic                         m_wr_ready,
   input  logic                         s_wr_done,
   output logic [OP_TAG_WIDTH-1:0]      m_commit_op_tag,
   output logic                         m_commit_valid,
`ifdef CPL_REQ_DROP_CNT_EN
   output logic [31:0]                  drop_count,
`endif
   output logic                         event_drop
);

   state_t state_q, state_d;

   // Holds s_cpl_ready low while reset is asserted; rises one edge later.
   logic                         live_q;
   logic [QUEUE_INDEX_WIDTH-1:0] queue_q;
   logic [CPL_DATA_WIDTH-1:0]    data_q;
   logic [REQ_TAG_WIDTH-1:0]     tag_cnt_q;
   logic [REQ_TAG_WIDTH-1:0]     tag_iss_q;
   logic [ADDR_WIDTH-1:0]        addr_q;
   logic [OP_TAG_WIDTH-1:0]      op_tag_q;
   logic                         cpl_fire;
   logic                         req_fire;
   logic                         wr_load;
   logic                         tag_hit;

   assign cpl_fire = s_cpl_valid & s_cpl_ready;
   assign req_fire = m_enq_req_valid & m_enq_req_ready;
   assign tag_hit  = (s_enq_resp_tag == tag_iss_q);

   assign m_enq_req_queue = queue_q;
   assign m_enq_req_tag   = tag_cnt_q;
   assign m_wr_addr       = addr_q;
   assign m_wr_data       = data_q;
   assign m_commit_op_tag = op_tag_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      s_cpl_ready      = 1'b0;
      m_enq_req_valid  = 1'b0;
      s_enq_resp_ready = 1'b0;
      m_wr_valid       = 1'b0;
      m_commit_valid   = 1'b0;
      event_drop       = 1'b0;
      wr_load          = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            s_cpl_ready = live_q;
            if (s_cpl_valid && live_q) state_d = S_REQ;
         end
         S_REQ: begin
            m_enq_req_valid = 1'b1;
            if (m_enq_req_ready) state_d = S_RESP;
         end
         S_RESP: begin
            s_enq_resp_ready = 1'b1;
            if (s_enq_resp_valid) begin
               // Stale responses are consumed and dropped; keep waiting.
               if (!tag_hit) begin
                  event_drop = 1'b1;
               end else if (s_enq_resp_full || s_enq_resp_error) begin
                  event_drop = 1'b1;
                  state_d    = S_IDLE;
               end else begin
                  wr_load = 1'b1;
                  state_d = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            m_wr_valid = 1'b1;
            if (m_wr_ready) state_d = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (s_wr_done) state_d = S_COMMIT;
         end
         S_COMMIT: begin
            m_commit_valid = 1'b1;
            state_d        = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         live_q    <= 1'b0;
         queue_q   <= '0;
         data_q    <= '0;
         tag_cnt_q <= '0;
         tag_iss_q <= '0;
         addr_q    <= '0;
         op_tag_q  <= '0;
      end else begin
         live_q <= 1'b1;
         if (cpl_fire) begin
            queue_q <= s_cpl_queue;
            data_q  <= s_cpl_data;
         end
         if (req_fire) begin
            tag_iss_q <= tag_cnt_q;
            tag_cnt_q <= tag_cnt_q + REQ_TAG_WIDTH'(1);
         end
         // The record MSB carries the slot phase so the consumer can
         // tell fresh entries from stale ones.
         if (wr_load) begin
            addr_q                   <= s_enq_resp_addr;
            op_tag_q                 <= s_enq_resp_op_tag;
            data_q[CPL_DATA_WIDTH-1] <= s_enq_resp_phase;
         end
      end
   end

`ifdef CPL_REQ_DROP_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_count <= '0;
      end else if (event_drop && (drop_count != 32'hFFFF_FFFF)) begin
         drop_count <= drop_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cpl_enqueue_requester.sv
// Self-checking bench for cpl_enqueue_requester.
// Scoreboard model plus directed scenarios; optional CPL_REQ_DROP_CNT_EN.
`timescale 1ns/1ps
module tb_cpl_enqueue_requester;
   import cpl_req_pkg::*;

   localparam int QW = 7;
   localparam int RW = 4;
   localparam int OW = 8;
   localparam int AW = 64;
   localparam int DW = CPL_DATA_WIDTH;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [QW-1:0] s_cpl_queue = '0;
   logic [DW-1:0] s_cpl_data = '0;
   logic          s_cpl_valid = 1'b0;
   logic          s_cpl_ready;
   logic [QW-1:0] m_enq_req_queue;
   logic [RW-1:0] m_enq_req_tag;
   logic          m_enq_req_valid;
   logic          m_enq_req_ready = 1'b1;
   logic [AW-1:0] s_enq_resp_addr = '0;
   logic          s_enq_resp_phase = 1'b0;
   logic [RW-1:0] s_enq_resp_tag = '0;
   logic [OW-1:0] s_enq_resp_op_tag = '0;
   logic          s_enq_resp_full = 1'b0;
   logic          s_enq_resp_error = 1'b0;
   logic          s_enq_resp_valid = 1'b0;
   logic          s_enq_resp_ready;
   logic [AW-1:0] m_wr_addr;
   logic [DW-1:0] m_wr_data;
   logic          m_wr_valid;
   logic          m_wr_ready = 1'b1;
   logic          s_wr_done = 1'b0;
   logic [OW-1:0] m_commit_op_tag;
   logic          m_commit_valid;
   logic          event_drop;
`ifdef CPL_REQ_DROP_CNT_EN
   logic [31:0]   drop_count;
`endif

   cpl_enqueue_requester dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .s_cpl_queue       (s_cpl_queue),
      .s_cpl_data        (s_cpl_data),
      .s_cpl_valid       (s_cpl_valid),
      .s_cpl_ready       (s_cpl_ready),
      .m_enq_req_queue   (m_enq_req_queue),
      .m_enq_req_tag     (m_enq_req_tag),
      .m_enq_req_valid   (m_enq_req_valid),
      .m_enq_req_ready   (m_enq_req_ready),
      .s_enq_resp_addr   (s_enq_resp_addr),
      .s_enq_resp_phase  (s_enq_resp_phase),
      .s_enq_resp_tag    (s_enq_resp_tag),
      .s_enq_resp_op_tag (s_enq_resp_op_tag),
      .s_enq_resp_full   (s_enq_resp_full),
      .s_enq_resp_error  (s_enq_resp_error),
      .s_enq_resp_valid  (s_enq_resp_valid),
      .s_enq_resp_ready  (s_enq_resp_ready),
      .m_wr_addr         (m_wr_addr),
      .m_wr_data         (m_wr_data),
      .m_wr_valid        (m_wr_valid),
      .m_wr_ready        (m_wr_ready),
      .s_wr_done         (s_wr_done),
      .m_commit_op_tag   (m_commit_op_tag),
      .m_commit_valid    (m_commit_valid),
`ifdef CPL_REQ_DROP_CNT_EN
      .drop_count        (drop_count),
`endif
      .event_drop        (event_drop)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;

   // Scoreboard / model state
   int            mtag = 0;
   int            iss_tag = 0;
   logic [QW-1:0] ev_queue = '0;
   logic [DW-1:0] ev_data = '0;
   bit            wr_pend = 0;
   logic [AW-1:0] exp_addr = '0;
   logic [DW-1:0] exp_data = '0;
   bit            cm_pend = 0;
   logic [OW-1:0] exp_op = '0;
   int            drop_pend = 0;
   int            drop_model = 0;
   int            tags_seen[$];
   int            busy = 0;
   bit            counting = 0;
   int            last_lat = -1;
   int            commits = 0;
   int            drops_seen = 0;
   logic [DW-1:0] last_wr_data = '0;
   logic [OW-1:0] last_op = '0;

   task automatic check(input string name, input logic [127:0] act,
                        input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         mtag = 0;
         wr_pend = 0;
         cm_pend = 0;
         drop_pend = 0;
         counting = 0;
      end else begin
         if (m_enq_req_valid && m_enq_req_ready) begin
            check("req_tag", m_enq_req_tag, mtag);
            check("req_queue", m_enq_req_queue, ev_queue);
            tags_seen.push_back(mtag);
            iss_tag = mtag;
            mtag = (mtag + 1) % 16;
         end
         if (m_wr_valid) begin
            check("write_expected", wr_pend, 1);
            if (wr_pend) begin
               check("wr_addr", m_wr_addr, exp_addr);
               check("wr_data", m_wr_data, exp_data);
               if (m_wr_ready) begin
                  wr_pend = 0;
                  last_wr_data = m_wr_data;
               end
            end
         end
         if (m_commit_valid) begin
            check("commit_expected", cm_pend, 1);
            if (cm_pend) check("commit_op_tag", m_commit_op_tag, exp_op);
            cm_pend = 0;
            commits++;
            last_op = m_commit_op_tag;
         end
         if (event_drop) begin
            check("drop_expected", drop_pend > 0, 1);
            if (drop_pend > 0) drop_pend--;
            drops_seen++;
         end
         if (counting) begin
            if (s_cpl_ready) begin
               last_lat = busy;
               counting = 0;
            end else begin
               busy++;
            end
         end
         if (s_cpl_valid && s_cpl_ready) begin
            counting = 1;
            busy = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tagname);
      check({tagname, "_cpl_ready"}, s_cpl_ready, 0);
      check({tagname, "_req_valid"}, m_enq_req_valid, 0);
      check({tagname, "_resp_ready"}, s_enq_resp_ready, 0);
      check({tagname, "_wr_valid"}, m_wr_valid, 0);
      check({tagname, "_commit"}, m_commit_valid, 0);
      check({tagname, "_drop"}, event_drop, 0);
      check({tagname, "_req_queue"}, m_enq_req_queue, 0);
      check({tagname, "_req_tag"}, m_enq_req_tag, 0);
      check({tagname, "_wr_addr"}, m_wr_addr, 0);
      check({tagname, "_wr_data"}, m_wr_data, 0);
      check({tagname, "_op_tag"}, m_commit_op_tag, 0);
`ifdef CPL_REQ_DROP_CNT_EN
      check({tagname, "_drop_count"}, drop_count, 0);
`endif
   endtask

   task automatic apply_reset();
      s_cpl_valid = 0;
      s_enq_resp_valid = 0;
      s_wr_done = 0;
      m_enq_req_ready = 1;
      m_wr_ready = 1;
      rst_n = 0;
      drop_model = 0;
      @(negedge clk);
      check_zero("rst");
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1;
      @(negedge clk);
      check("ready_during_release", s_cpl_ready, 0);
      tick();
      check("ready_after_release", s_cpl_ready, 1);
      tags_seen.delete();
   endtask

   task automatic send_event(input logic [QW-1:0] q, input logic [DW-1:0] d);
      int n = 0;
      while (!s_cpl_ready && n < 50) begin
         tick();
         n++;
      end
      check("cpl_ready_wait", s_cpl_ready, 1);
      ev_queue = q;
      ev_data = d;
      s_cpl_queue = q;
      s_cpl_data = d;
      s_cpl_valid = 1;
      tick();
      s_cpl_valid = 0;
   endtask

   task automatic send_resp(input logic [RW-1:0] tag, input bit full,
                            input bit err, input bit ph,
                            input logic [AW-1:0] addr,
                            input logic [OW-1:0] op);
      int n = 0;
      while (!s_enq_resp_ready && n < 50) begin
         tick();
         n++;
      end
      check("resp_ready_wait", s_enq_resp_ready, 1);
      if ((int'(tag) == iss_tag) && !full && !err) begin
         exp_addr = addr;
         exp_data = {ph, ev_data[DW-2:0]};
         wr_pend = 1;
         exp_op = op;
         cm_pend = 1;
      end else begin
         drop_pend++;
         drop_model++;
      end
      s_enq_resp_tag = tag;
      s_enq_resp_full = full;
      s_enq_resp_error = err;
      s_enq_resp_phase = ph;
      s_enq_resp_addr = addr;
      s_enq_resp_op_tag = op;
      s_enq_resp_valid = 1;
      tick();
      s_enq_resp_valid = 0;
      s_enq_resp_full = 0;
      s_enq_resp_error = 0;
   endtask

   task automatic finish_write(input int stall, input bit do_done);
      int n = 0;
      while (!m_wr_valid && n < 50) begin
         tick();
         n++;
      end
      check("wr_valid_wait", m_wr_valid, 1);
      repeat (stall) begin
         tick();
         check("wr_held", m_wr_valid, 1);
      end
      m_wr_ready = 1;
      tick();
      if (do_done) begin
         s_wr_done = 1;
         tick();
         s_wr_done = 0;
      end
   endtask

   initial begin
      int commits_before;
      apply_reset();

      // Stray write-done in IDLE must be ignored
      s_wr_done = 1;
      tick();
      s_wr_done = 0;

      // Basic zero-wait operation
      send_event(7'd5, 128'h0123_4567_89AB_CDEF_0011_2233_4455_66A5);
      send_resp(4'd0, 0, 0, 1, 64'h0000_0000_0000_1000, 8'h3C);
      finish_write(0, 1);
      repeat (2) tick();
      check("op1_tag", tags_seen[0], 0);
      check("op1_commits", commits, 1);
      check("op1_op_tag", last_op, 8'h3C);
      check("op1_msb", last_wr_data[DW-1], 1);
      check("op1_low", last_wr_data[7:0], 8'hA5);
      check("op1_latency", last_lat, 5);

      // Full response drops the event
      send_event(7'd9, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
      send_resp(4'd1, 1, 0, 1, 64'h2000, 8'h55);
      check("full_ready_back", s_cpl_ready, 1);
      tick();
      check("full_drops", drops_seen, 1);
      check("full_commits", commits, 1);
      check("full_latency", last_lat, 2);

      // Stale tag discarded, matching one completes; write stalled
      send_event(7'h7F, 128'hF0E0_D0C0_B0A0_9080_7060_5040_3020_1000);
      send_resp(4'd3, 0, 0, 1, 64'h3000, 8'h99);
      m_wr_ready = 0;
      send_resp(4'd2, 0, 0, 0, 64'hDEAD_BEEF_0000_0040, 8'h81);
      finish_write(2, 1);
      repeat (2) tick();
      check("stale_tag", tags_seen[2], 2);
      check("stale_drops", drops_seen, 2);
      check("stale_commits", commits, 2);
      check("stale_op_tag", last_op, 8'h81);
      check("stale_msb", last_wr_data[DW-1], 0);

      // Error response drops the event
      send_event(7'd1, 128'h5);
      send_resp(4'd3, 0, 1, 1, 64'h4000, 8'h11);
      tick();
      check("err_drops", drops_seen, 3);
      check("err_commits", commits, 2);
`ifdef CPL_REQ_DROP_CNT_EN
      check("drop_count_3", drop_count, drop_model);
`endif

      // Tag sequence across wrap
      apply_reset();
      for (int i = 0; i < 17; i++) begin
         send_event(QW'(i), {4{32'(i) * 32'h1111_1111}});
         send_resp(RW'(iss_tag_next()), 0, 0, i[0], AW'(i) << 6,
                   OW'(i + 8'h40));
         finish_write(0, 1);
      end
      repeat (2) tick();
      for (int i = 0; i < 17; i++) check("wrap_tag", tags_seen[i], i % 16);

      // One drop, then reset while waiting for write-done
      send_event(7'd3, 128'hABC);
      send_resp(RW'(iss_tag_next()), 1, 0, 0, 64'h0, 8'h0);
      tick();
`ifdef CPL_REQ_DROP_CNT_EN
      check("drop_count_1", drop_count, drop_model);
`endif
      send_event(7'd4, 128'hCAFE);
      send_resp(RW'(iss_tag_next()), 0, 0, 1, 64'h5000, 8'h77);
      finish_write(0, 0);
      commits_before = commits;
      rst_n = 0;
      #1;
      check_zero("midop");
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1;
      s_wr_done = 1;
      tick();
      s_wr_done = 0;
      repeat (5) tick();
      check("midop_no_commit", commits, commits_before);
      check("midop_idle", s_cpl_ready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   // Tag the bench expects the DUT to have issued for the current request;
   // evaluated after send_event, before the request handshake is seen.
   function automatic int iss_tag_next();
      return mtag;
   endfunction

endmodule
